// File: rtl/branch_pc_sequencer.sv
// PC sequencer: owns the PC, fetches over req/ready, issues over valid/stall, redirects on beq/bne.
// Optional macro BRANCH_DELAY_SLOT_EN: fetch/issue instr_pc+4 while the branch is pending.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  OP_BEQ   = 6'h04,
  parameter logic [5:0]  OP_BNE   = 6'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        alu_zero,
  input  logic        br_resolve,
  output logic        br_pending,
  output logic [7:0]  br_taken_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT_BR} state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state, state_n;
  logic [31:0] pc;
  logic [15:0] off;
  logic        is_br, is_bne;
  logic        cap, adv, redir, br_start;
  logic        taken_now, redir_taken;
  logic [15:0] br_off;
  logic        br_bne;
  logic [31:0] br_base, br_next;
  logic [5:0]  op;

  assign op        = instr[31:26];
  assign imem_addr = pc;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        slot, res_vld, res_taken;
  logic [15:0] br_off_q;
  logic        br_bne_q;
  logic [31:0] br_pc_q;

  // instr_pc/off are overwritten by the slot instruction, so the branch keeps its own copy
  assign br_off      = br_off_q;
  assign br_bne      = br_bne_q;
  assign br_base     = br_pc_q;
  assign redir_taken = res_vld ? res_taken : taken_now;
`else
  assign br_off      = off;
  assign br_bne      = is_bne;
  assign br_base     = instr_pc;
  assign redir_taken = taken_now;
`endif

  assign taken_now = br_bne ? ~alu_zero : alu_zero;
  assign br_next   = redir_taken ? (br_base + 32'd4 + {{14{br_off[15]}}, br_off, 2'b00})
                                 : (br_base + 32'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cap         = 1'b0;
    adv         = 1'b0;
    redir       = 1'b0;
    br_start    = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: if (start) state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          cap     = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          if (is_br) begin
            br_start = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
            state_n  = FETCH;
`else
            state_n  = WAIT_BR;
`endif
          end
`ifdef BRANCH_DELAY_SLOT_EN
          else if (slot) begin
            // resolve may land in the same cycle the slot is accepted
            if (res_vld || br_resolve) begin
              redir   = 1'b1;
              state_n = start ? FETCH : IDLE;
            end else begin
              state_n = WAIT_BR;
            end
          end
`endif
          else begin
            adv     = 1'b1;
            state_n = start ? FETCH : IDLE;
          end
        end
      end
      WAIT_BR: begin
        if (br_resolve) begin
          redir   = 1'b1;
          state_n = start ? FETCH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= PC_INIT;
      instr_out    <= '0;
      instr_pc     <= '0;
      off          <= '0;
      is_br        <= 1'b0;
      is_bne       <= 1'b0;
      br_pending   <= 1'b0;
      br_taken_cnt <= '0;
    end else begin
      if (cap) begin
        instr_out <= instr;
        instr_pc  <= pc;
        off       <= instr[15:0];
`ifdef BRANCH_DELAY_SLOT_EN
        is_br     <= ((op == OP_BEQ) || (op == OP_BNE)) && !slot;
`else
        is_br     <= (op == OP_BEQ) || (op == OP_BNE);
`endif
        is_bne    <= (op == OP_BNE);
      end
      if (adv) pc <= pc + 32'd4;
      if (br_start) begin
        br_pending <= 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        pc         <= pc + 32'd4;
`endif
      end
      if (redir) begin
        pc         <= br_next;
        br_pending <= 1'b0;
        if (redir_taken) br_taken_cnt <= br_taken_cnt + 8'd1;
      end
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot      <= 1'b0;
      res_vld   <= 1'b0;
      res_taken <= 1'b0;
      br_off_q  <= '0;
      br_bne_q  <= 1'b0;
      br_pc_q   <= '0;
    end else begin
      if (br_start) begin
        slot     <= 1'b1;
        br_pc_q  <= instr_pc;
        br_off_q <= off;
        br_bne_q <= is_bne;
      end
      if (redir) begin
        slot    <= 1'b0;
        res_vld <= 1'b0;
      end else if (br_pending && br_resolve && state != WAIT_BR && !res_vld) begin
        res_vld   <= 1'b1;
        res_taken <= taken_now;
      end
    end
  end
`endif

endmodule
